grf_wb_queue: RTL and testbench

Write-back queue between the CPU's result producers and the general register file write port. It accepts register-write requests from two producers (A: ALU/link path, B: memory-load path) through valid/ready handshakes and buffers them in a DEPTH-entry FIFO. It retires at most one write per cycle to the register file in strict arrival order. It also answers two same-cycle forwarding lookups, so decode sees values that are still queued.

---
 rtl/grf_wb_queue.sv | 122 ++++++++++++
 tb/tb_grf_wb_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_queue.sv
// Write-back queue: two producers feed a DEPTH-entry FIFO that retires one
// register-file write per cycle and answers two forwarding lookups.
module grf_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [31:0]              a_pc,
  input  logic [4:0]               a_reg,
  input  logic [31:0]              a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [31:0]              b_pc,
  input  logic [4:0]               b_reg,
  input  logic [31:0]              b_data,
  output logic                     w_en,
  output logic [31:0]              w_pc,
  output logic [4:0]               w_reg,
  output logic [31:0]              w_data,
  input  logic [4:0]               q1_reg,
  output logic                     q1_hit,
  output logic [31:0]              q1_data,
  input  logic [4:0]               q2_reg,
  output logic                     q2_hit,
  output logic [31:0]              q2_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] data;
  } ent_t;

  ent_t            r_mem [DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;

  logic            w_push_a;
  logic            w_push_b;
  logic            w_pop;
  logic [PW-1:0]   w_slot_b;
  logic [4:0]      w_qr [2];
  logic            w_qh [2];
  logic [31:0]     w_qd [2];

  assign count    = r_cnt;
  assign a_ready  = (r_cnt <= CW'(DEPTH - 1));
  assign b_ready  = a_valid ? (r_cnt <= CW'(DEPTH - 2))
                            : (r_cnt <= CW'(DEPTH - 1));

  // Register 0 handshakes complete but never enter the queue.
  assign w_push_a = a_valid && a_ready && (a_reg != 5'd0);
  assign w_push_b = b_valid && b_ready && (b_reg != 5'd0);
  assign w_pop    = (r_cnt != '0);
  assign w_slot_b = r_wr + PW'(w_push_a);

  always_ff @(posedge clk) begin
    if (w_push_a) r_mem[r_wr] <= '{pc: a_pc, rg: a_reg, data: a_data};
    if (w_push_b) r_mem[w_slot_b] <= '{pc: b_pc, rg: b_reg, data: b_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      w_en   <= 1'b0;
      w_pc   <= '0;
      w_reg  <= '0;
      w_data <= '0;
    end else begin
      w_en <= w_pop;
      if (w_pop) begin
        w_pc   <= r_mem[r_rd].pc;
        w_reg  <= r_mem[r_rd].rg;
        w_data <= r_mem[r_rd].data;
        r_rd   <= r_rd + PW'(1);
      end
      r_wr  <= r_wr + PW'(w_push_a) + PW'(w_push_b);
      r_cnt <= r_cnt + CW'(w_push_a) + CW'(w_push_b) - CW'(w_pop);
    end
  end

  assign w_qr[0] = q1_reg;
  assign w_qr[1] = q2_reg;

  // Oldest source first so younger matches overwrite the result.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      w_qh[j] = 1'b0;
      w_qd[j] = '0;
      if (w_en && (w_reg == w_qr[j])) begin
        w_qh[j] = 1'b1;
        w_qd[j] = w_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if ((CW'(k) < r_cnt) &&
            (r_mem[r_rd + PW'(k)].rg == w_qr[j])) begin
          w_qh[j] = 1'b1;
          w_qd[j] = r_mem[r_rd + PW'(k)].data;
        end
      end
      if (w_qr[j] == 5'd0) begin
        w_qh[j] = 1'b0;
        w_qd[j] = '0;
      end
    end
  end

  assign q1_hit  = w_qh[0];
  assign q1_data = w_qd[0];
  assign q2_hit  = w_qh[1];
  assign q2_data = w_qd[1];

endmodule

// File: tb/tb_grf_wb_queue.sv
// Randomized and directed bench for grf_wb_queue against a queue-based
// reference model of the write-back ordering and forwarding rules.
module tb_grf_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [31:0] a_pc, a_data, b_pc, b_data;
  logic [4:0]  a_reg, b_reg;
  logic        w_en;
  logic [31:0] w_pc, w_data;
  logic [4:0]  w_reg;
  logic [4:0]  q1_reg, q2_reg;
  logic        q1_hit, q2_hit;
  logic [31:0] q1_data, q2_data;
  logic [2:0]  count;

  always #5 clk = ~clk;

  grf_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_pc(a_pc),
    .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_pc(b_pc),
    .b_reg(b_reg), .b_data(b_data),
    .w_en(w_en), .w_pc(w_pc), .w_reg(w_reg), .w_data(w_data),
    .q1_reg(q1_reg), .q1_hit(q1_hit), .q1_data(q1_data),
    .q2_reg(q2_reg), .q2_hit(q2_hit), .q2_data(q2_data),
    .count(count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        mw_en;
  logic [31:0] mw_pc, mw_data;
  logic [4:0]  mw_reg;
  int          n_acc, n_ret;
  int          checks, failures;

  function automatic bit m_ar();
    return mq.size() < DEPTH;
  endfunction

  function automatic bit m_br();
    return a_valid ? (mq.size() <= DEPTH - 2) : (mq.size() < DEPTH);
  endfunction

  function automatic logic [32:0] m_fwd(input logic [4:0] q);
    if (q == 5'd0) return 33'd0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].rg == q) return {1'b1, mq[i].data};
    if (mw_en && mw_reg == q) return {1'b1, mw_data};
    return 33'd0;
  endfunction

  task automatic set_a(input bit v, input logic [4:0] r,
                       input logic [31:0] d, input logic [31:0] p);
    a_valid = v; a_reg = r; a_data = d; a_pc = p;
  endtask

  task automatic set_b(input bit v, input logic [4:0] r,
                       input logic [31:0] d, input logic [31:0] p);
    b_valid = v; b_reg = r; b_data = d; b_pc = p;
  endtask

  task automatic m_clear();
    mq.delete();
    mw_en = 0; mw_pc = 0; mw_reg = 0; mw_data = 0;
  endtask

  // Advance the model with the inputs now applied, then clock the DUT.
  task automatic tick();
    bit pa, pb;
    ent_t e;
    pa = a_valid && m_ar() && (a_reg != 5'd0);
    pb = b_valid && m_br() && (b_reg != 5'd0);
    if (mq.size() > 0) begin
      e = mq.pop_front();
      mw_en = 1; mw_pc = e.pc; mw_reg = e.rg; mw_data = e.data;
      n_ret++;
    end else begin
      mw_en = 0;
    end
    if (pa) begin mq.push_back('{a_pc, a_reg, a_data}); n_acc++; end
    if (pb) begin mq.push_back('{b_pc, b_reg, b_data}); n_acc++; end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    q1_reg = 0; q2_reg = 0;
    m_clear();
    #2;
    checks++; if (w_en !== 1'b0) begin failures++; $display("FAIL rst_w_en got=%0h exp=0", w_en); end
    checks++; if (w_pc !== 32'd0) begin failures++; $display("FAIL rst_w_pc got=%0h exp=0", w_pc); end
    checks++; if (w_reg !== 5'd0) begin failures++; $display("FAIL rst_w_reg got=%0h exp=0", w_reg); end
    checks++; if (w_data !== 32'd0) begin failures++; $display("FAIL rst_w_data got=%0h exp=0", w_data); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (q1_hit !== 1'b0 || q1_data !== 32'd0) begin failures++; $display("FAIL rst_q1 got=%0h/%0h exp=0/0", q1_hit, q1_data); end
    @(negedge clk);
    reset = 0;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b%0b exp=11", a_ready, b_ready); end
  endtask

  task automatic test_single();
    @(negedge clk);
    set_a(1, 5, 32'h1234, 32'h3000);
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%0b exp=1", a_ready); end
    tick();
    checks++; if (count !== 3'd1 || w_en !== 1'b0) begin failures++; $display("FAIL single_push got=%0d/%0b exp=1/0", count, w_en); end
    idle();
    tick();
    checks++; if (w_en !== 1'b1 || w_reg !== 5'd5) begin failures++; $display("FAIL single_wr got=%0b/%0d exp=1/5", w_en, w_reg); end
    checks++; if (w_data !== 32'h1234 || w_pc !== 32'h3000) begin failures++; $display("FAIL single_wd got=%0h/%0h exp=1234/3000", w_data, w_pc); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_cnt got=%0d exp=0", count); end
    tick();
    checks++; if (w_en !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL single_after got=%0b/%0d exp=0/0", w_en, count); end
  endtask

  task automatic test_dual();
    @(negedge clk);
    set_a(1, 3, 32'hA, 32'h100);
    set_b(1, 4, 32'hB, 32'h104);
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin failures++; $display("FAIL dual_ready got=%0b%0b exp=11", a_ready, b_ready); end
    tick();
    checks++; if (count !== 3'd2 || w_en !== 1'b0) begin failures++; $display("FAIL dual_cnt got=%0d/%0b exp=2/0", count, w_en); end
    idle();
    tick();
    checks++; if (w_en !== 1'b1 || w_reg !== 5'd3 || w_data !== 32'hA) begin failures++; $display("FAIL dual_first got=%0b/%0d/%0h exp=1/3/a", w_en, w_reg, w_data); end
    tick();
    checks++; if (w_en !== 1'b1 || w_reg !== 5'd4 || w_data !== 32'hB) begin failures++; $display("FAIL dual_second got=%0b/%0d/%0h exp=1/4/b", w_en, w_reg, w_data); end
    tick();
    checks++; if (w_en !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL dual_empty got=%0b/%0d exp=0/0", w_en, count); end
  endtask

  task automatic test_back_to_back();
    n_acc = 0; n_ret = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c < 8) begin
        set_a(1, 5'(1 + 2 * c), 32'hC000 + 32'(c), 32'h5000 + 32'(8 * c));
        set_b(1, 5'(2 + 2 * c), 32'hD000 + 32'(c), 32'h5004 + 32'(8 * c));
      end else begin
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
      end
      #1;
      checks++; if (a_ready !== m_ar() || b_ready !== m_br()) begin failures++; $display("FAIL fill_ready c=%0d got=%0b%0b exp=%0b%0b", c, a_ready, b_ready, m_ar(), m_br()); end
      tick();
      checks++; if (count !== 3'(mq.size()) || w_en !== mw_en) begin failures++; $display("FAIL fill_state c=%0d got=%0d/%0b exp=%0d/%0b", c, count, w_en, mq.size(), mw_en); end
      checks++; if (w_reg !== mw_reg || w_data !== mw_data || w_pc !== mw_pc) begin failures++; $display("FAIL fill_wr c=%0d got=%0d/%0h/%0h exp=%0d/%0h/%0h", c, w_reg, w_data, w_pc, mw_reg, mw_data, mw_pc); end
    end
    checks++; if (n_ret !== n_acc || count !== 3'd0) begin failures++; $display("FAIL fill_total got=%0d/%0d exp=%0d/0", n_ret, count, n_acc); end
  endtask

  task automatic test_zero_filter();
    @(negedge clk);
    q1_reg = 0;
    set_a(1, 0, 32'hFFFF, 32'h4000);
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL zero_ready got=%0b exp=1", a_ready); end
    checks++; if (q1_hit !== 1'b0 || q1_data !== 32'd0) begin failures++; $display("FAIL zero_lookup got=%0b/%0h exp=0/0", q1_hit, q1_data); end
    tick();
    checks++; if (count !== 3'd0 || w_en !== 1'b0) begin failures++; $display("FAIL zero_cnt got=%0d/%0b exp=0/0", count, w_en); end
    idle();
    tick();
    checks++; if (w_en !== 1'b0) begin failures++; $display("FAIL zero_wen got=%0b exp=0", w_en); end
  endtask

  task automatic test_forward_priority();
    @(negedge clk);
    set_a(1, 7, 32'h33, 32'h600);
    #1;
    tick();
    @(negedge clk);
    set_a(1, 7, 32'h11, 32'h604);
    set_b(1, 7, 32'h22, 32'h608);
    #1;
    tick();
    idle();
    q1_reg = 7; q2_reg = 9;
    #1;
    checks++; if (q1_hit !== 1'b1 || q1_data !== 32'h22) begin failures++; $display("FAIL fwd_newest got=%0b/%0h exp=1/22", q1_hit, q1_data); end
    checks++; if (q2_hit !== 1'b0 || q2_data !== 32'd0) begin failures++; $display("FAIL fwd_miss got=%0b/%0h exp=0/0", q2_hit, q2_data); end
    checks++; if (w_en !== 1'b1 || w_data !== 32'h33) begin failures++; $display("FAIL fwd_wreg got=%0b/%0h exp=1/33", w_en, w_data); end
    tick();
    checks++; if (q1_hit !== 1'b1 || q1_data !== 32'h22) begin failures++; $display("FAIL fwd_one got=%0b/%0h exp=1/22", q1_hit, q1_data); end
    tick();
    checks++; if (q1_hit !== 1'b1 || q1_data !== 32'h22 || count !== 3'd0) begin failures++; $display("FAIL fwd_wonly got=%0b/%0h/%0d exp=1/22/0", q1_hit, q1_data, count); end
    tick();
    checks++; if (q1_hit !== 1'b0 || q1_data !== 32'd0) begin failures++; $display("FAIL fwd_gone got=%0b/%0h exp=0/0", q1_hit, q1_data); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    set_a(1, 10, 32'hA0, 32'h700);
    set_b(1, 11, 32'hB0, 32'h704);
    #1;
    tick();
    @(negedge clk);
    set_a(1, 12, 32'hC0, 32'h708);
    set_b(1, 13, 32'hD0, 32'h70C);
    q1_reg = 12;
    #1;
    tick();
    checks++; if (count !== 3'd3 || w_en !== 1'b1) begin failures++; $display("FAIL ar_pre got=%0d/%0b exp=3/1", count, w_en); end
    #2;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    reset = 1;
    #1;
    m_clear();
    checks++; if (count !== 3'd0 || w_en !== 1'b0) begin failures++; $display("FAIL ar_now got=%0d/%0b exp=0/0", count, w_en); end
    checks++; if (q1_hit !== 1'b0 || w_reg !== 5'd0) begin failures++; $display("FAIL ar_clear got=%0b/%0d exp=0/0", q1_hit, w_reg); end
    @(negedge clk);
    reset = 0;
    #1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (w_en !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL ar_after c=%0d got=%0b/%0d exp=0/0", c, w_en, count); end
    end
  endtask

  task automatic test_random();
    logic [32:0] f1, f2;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      set_a(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, $urandom);
      set_b(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, $urandom);
      q1_reg = 5'($urandom_range(0, 7));
      q2_reg = 5'($urandom_range(0, 7));
      #1;
      f1 = m_fwd(q1_reg);
      f2 = m_fwd(q2_reg);
      checks++; if (a_ready !== m_ar() || b_ready !== m_br()) begin failures++; $display("FAIL rnd_ready c=%0d got=%0b%0b exp=%0b%0b", c, a_ready, b_ready, m_ar(), m_br()); end
      checks++; if (q1_hit !== f1[32] || q1_data !== f1[31:0]) begin failures++; $display("FAIL rnd_q1 c=%0d got=%0b/%0h exp=%0b/%0h", c, q1_hit, q1_data, f1[32], f1[31:0]); end
      checks++; if (q2_hit !== f2[32] || q2_data !== f2[31:0]) begin failures++; $display("FAIL rnd_q2 c=%0d got=%0b/%0h exp=%0b/%0h", c, q2_hit, q2_data, f2[32], f2[31:0]); end
      tick();
      checks++; if (count !== 3'(mq.size()) || w_en !== mw_en) begin failures++; $display("FAIL rnd_state c=%0d got=%0d/%0b exp=%0d/%0b", c, count, w_en, mq.size(), mw_en); end
      checks++; if (w_reg !== mw_reg || w_data !== mw_data || w_pc !== mw_pc) begin failures++; $display("FAIL rnd_wr c=%0d got=%0d/%0h/%0h exp=%0d/%0h/%0h", c, w_reg, w_data, w_pc, mw_reg, mw_data, mw_pc); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    n_acc = 0; n_ret = 0;
    test_reset();
    test_single();
    test_dual();
    test_back_to_back();
    test_zero_filter();
    test_forward_priority();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
